// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side capture fields, data-memory return path and WB outputs.
// The pipeline side uses master; the stage uses slave.
interface mem_wb_stage_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_ADDR_W = 5
);
  logic                 validMEM;
  logic                 flushWB;
  logic [RF_ADDR_W-1:0] rdAddrMEM;
  logic                 rdWriteEnMEM;
  logic [1:0]           destinationSelectMEM;
  logic [2:0]           loadFunct3MEM;
  logic                 isCompressedMEM;
  logic [XLEN-1:0]      pcMEM;
  logic [XLEN-1:0]      rdWriteDataMEM;
  logic [XLEN-1:0]      dmAddrMEM;
  logic [XLEN-1:0]      dmLoadData;
  logic                 dmLoadValid;

  logic                 stallWB;
  logic                 validWB;
  logic [RF_ADDR_W-1:0] rdAddrWB;
  logic                 rdWriteEnWB;
  logic [XLEN-1:0]      rdWriteDataWB;
  logic [XLEN-1:0]      pcWB;
  logic [XLEN-1:0]      dmAddrWB;

  modport master (
    output validMEM, flushWB, rdAddrMEM, rdWriteEnMEM, destinationSelectMEM,
           loadFunct3MEM, isCompressedMEM, pcMEM, rdWriteDataMEM, dmAddrMEM,
           dmLoadData, dmLoadValid,
    input  stallWB, validWB, rdAddrWB, rdWriteEnWB, rdWriteDataWB, pcWB, dmAddrWB
  );

  modport slave (
    input  validMEM, flushWB, rdAddrMEM, rdWriteEnMEM, destinationSelectMEM,
           loadFunct3MEM, isCompressedMEM, pcMEM, rdWriteDataMEM, dmAddrMEM,
           dmLoadData, dmLoadValid,
    output stallWB, validWB, rdAddrWB, rdWriteEnWB, rdWriteDataWB, pcWB, dmAddrWB
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers MEM results, waits for late load data while stalling
// the pipeline, extracts/extends load data and selects the register-file writeback value.
module mem_wb_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RF_ADDR_W  = 5,
  parameter bit          ZERO_GUARD = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_IMM  = 2'd1;
  localparam logic [1:0] WB_SEL_LOAD = 2'd2;
  localparam logic [1:0] WB_SEL_PC   = 2'd3;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd_addr;
    logic                 rd_we;
    logic [1:0]           sel;
    logic [2:0]           funct3;
    logic                 is_c;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rd_data;
    logic [XLEN-1:0]      dm_addr;
  } wb_fields_t;

  state_e          state_q, state_d;
  wb_fields_t      fields_q, fields_d;
  logic [XLEN-1:0] load_buf_q, load_buf_d;

  logic [1:0]      offset;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     word_v;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] wb_data;

  // State and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fields_q   <= '0;
      load_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      fields_q   <= fields_d;
      load_buf_q <= load_buf_d;
    end
  end

  // Capture in RUN; in WAIT_LOAD everything holds until the load word returns
  always_comb begin
    state_d    = state_q;
    fields_d   = fields_q;
    load_buf_d = load_buf_q;
    case (state_q)
      RUN: begin
        fields_d.valid   = bus.validMEM & ~bus.flushWB;
        fields_d.rd_addr = bus.rdAddrMEM;
        fields_d.rd_we   = bus.rdWriteEnMEM;
        fields_d.sel     = bus.destinationSelectMEM;
        fields_d.funct3  = bus.loadFunct3MEM;
        fields_d.is_c    = bus.isCompressedMEM;
        fields_d.pc      = bus.pcMEM;
        fields_d.rd_data = bus.rdWriteDataMEM;
        fields_d.dm_addr = bus.dmAddrMEM;
        if (bus.dmLoadValid) begin
          load_buf_d = bus.dmLoadData;
        end
        if (fields_d.valid && (bus.destinationSelectMEM == WB_SEL_LOAD) && !bus.dmLoadValid) begin
          state_d = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (bus.dmLoadValid) begin
          load_buf_d = bus.dmLoadData;
          state_d    = RUN;
        end
      end
    endcase
  end

  // Byte/halfword lane selection and extension; halfword ignores offset[0]
  always_comb begin
    offset   = fields_q.dm_addr[1:0];
    byte_v   = load_buf_q[{offset, 3'b000} +: 8];
    half_v   = load_buf_q[{offset[1], 4'b0000} +: 16];
    word_v   = load_buf_q[31:0];
    load_ext = '0;
    case (fields_q.funct3)
      3'b000:  load_ext = XLEN'($signed(byte_v));
      3'b001:  load_ext = XLEN'($signed(half_v));
      3'b010:  load_ext = XLEN'($signed(word_v));
      3'b100:  load_ext = XLEN'(byte_v);
      3'b101:  load_ext = XLEN'(half_v);
      default: load_ext = '0;
    endcase
  end

  // Writeback value select; an empty stage drives zero
  always_comb begin
    wb_data = '0;
    case (fields_q.sel)
      WB_SEL_ALU:  wb_data = fields_q.rd_data;
      WB_SEL_IMM:  wb_data = fields_q.rd_data;
      WB_SEL_LOAD: wb_data = load_ext;
      WB_SEL_PC:   wb_data = fields_q.pc + (fields_q.is_c ? XLEN'(2) : XLEN'(4));
      default:     wb_data = '0;
    endcase
    if (!fields_q.valid) begin
      wb_data = '0;
    end
  end

  assign bus.stallWB       = (state_q == WAIT_LOAD) && !bus.dmLoadValid;
  assign bus.validWB       = fields_q.valid;
  assign bus.rdAddrWB      = fields_q.rd_addr;
  assign bus.rdWriteEnWB   = fields_q.valid & fields_q.rd_we & (state_q == RUN)
                             & ~(ZERO_GUARD & (fields_q.rd_addr == '0));
  assign bus.rdWriteDataWB = wb_data;
  assign bus.pcWB          = fields_q.pc;
  assign bus.dmAddrWB      = fields_q.dm_addr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand-written load-wait sequences,
// then random traffic against a behavioural model of the stage.
module tb_mem_wb_stage;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_IMM  = 2'd1;
  localparam logic [1:0] SEL_LOAD = 2'd2;
  localparam logic [1:0] SEL_PC   = 2'd3;
  localparam int unsigned NV = 14;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_wb_stage_if #(.XLEN(32), .RF_ADDR_W(5)) bus ();

  mem_wb_stage #(.XLEN(32), .RF_ADDR_W(5), .ZERO_GUARD(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic        isc;
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] ld;
    logic        ldv;
    logic        exp_valid;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [NV];

  // behavioural model of the registered stage contents
  logic        m_valid, m_we, m_isc, m_wait;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [2:0]  m_f3;
  logic [31:0] m_pc, m_data, m_addr, m_buf;

  function automatic vec_t mk(input logic valid, input logic flush, input logic [4:0] rd,
                              input logic we, input logic [1:0] sel, input logic [2:0] f3,
                              input logic isc, input logic [31:0] pc, input logic [31:0] data,
                              input logic [31:0] addr, input logic [31:0] ld, input logic ldv,
                              input logic exp_valid, input logic exp_we,
                              input logic [31:0] exp_data);
    vec_t v;
    v.valid = valid; v.flush = flush; v.rd = rd; v.we = we; v.sel = sel; v.f3 = f3;
    v.isc = isc; v.pc = pc; v.data = data; v.addr = addr; v.ld = ld; v.ldv = ldv;
    v.exp_valid = exp_valid; v.exp_we = exp_we; v.exp_data = exp_data;
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
    int unsigned sh_b;
    int unsigned sh_h;
    logic [31:0] b;
    logic [31:0] h;
    sh_b = 8 * int'(addr[1:0]);
    sh_h = 16 * int'(addr[1]);
    b = (w >> sh_b) & 32'h0000_00FF;
    h = (w >> sh_h) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.validMEM             = v.valid;
    bus.flushWB              = v.flush;
    bus.rdAddrMEM            = v.rd;
    bus.rdWriteEnMEM         = v.we;
    bus.destinationSelectMEM = v.sel;
    bus.loadFunct3MEM        = v.f3;
    bus.isCompressedMEM      = v.isc;
    bus.pcMEM                = v.pc;
    bus.rdWriteDataMEM       = v.data;
    bus.dmAddrMEM            = v.addr;
    bus.dmLoadData           = v.ld;
    bus.dmLoadValid          = v.ldv;
  endtask

  task automatic drive_idle();
    apply(mk(0, 0, 5'd0, 0, SEL_ALU, 3'b000, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_data;
    logic        exp_we;
    exp_data = 32'h0;
    if (m_valid) begin
      case (m_sel)
        SEL_ALU, SEL_IMM: exp_data = m_data;
        SEL_LOAD:         exp_data = ref_load(m_f3, m_addr, m_buf);
        default:          exp_data = m_pc + (m_isc ? 32'd2 : 32'd4);
      endcase
    end
    exp_we = m_valid & m_we & ~m_wait & (m_rd != 5'd0);
    check({tag, "_stall"}, 32'(bus.stallWB), 32'(m_wait & ~bus.dmLoadValid));
    check({tag, "_valid"}, 32'(bus.validWB), 32'(m_valid));
    check({tag, "_rd"},    32'(bus.rdAddrWB), 32'(m_rd));
    check({tag, "_we"},    32'(bus.rdWriteEnWB), 32'(exp_we));
    check({tag, "_data"},  bus.rdWriteDataWB, exp_data);
    check({tag, "_pc"},    bus.pcWB, m_pc);
    check({tag, "_addr"},  bus.dmAddrWB, m_addr);
  endtask

  task automatic model_step();
    if (rst) begin
      m_valid = 0; m_rd = '0; m_we = 0; m_sel = SEL_ALU; m_f3 = '0; m_isc = 0;
      m_pc = '0; m_data = '0; m_addr = '0; m_buf = '0; m_wait = 0;
    end else if (!m_wait) begin
      m_valid = bus.validMEM & ~bus.flushWB;
      m_rd    = bus.rdAddrMEM;
      m_we    = bus.rdWriteEnMEM;
      m_sel   = bus.destinationSelectMEM;
      m_f3    = bus.loadFunct3MEM;
      m_isc   = bus.isCompressedMEM;
      m_pc    = bus.pcMEM;
      m_data  = bus.rdWriteDataMEM;
      m_addr  = bus.dmAddrMEM;
      if (bus.dmLoadValid) m_buf = bus.dmLoadData;
      m_wait  = m_valid && (m_sel == SEL_LOAD) && !bus.dmLoadValid;
    end else if (bus.dmLoadValid) begin
      m_buf  = bus.dmLoadData;
      m_wait = 0;
    end
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;

    vecs[0]  = mk(1, 0, 5'd5,  1, SEL_ALU,  3'b000, 0, 32'h0000_1000, 32'h0000_1234, 32'h0,         32'h0,         0, 1, 1, 32'h0000_1234);
    vecs[1]  = mk(1, 0, 5'd7,  1, SEL_IMM,  3'b000, 0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,         32'h0,         0, 1, 1, 32'hDEAD_BEEF);
    vecs[2]  = mk(1, 0, 5'd3,  1, SEL_LOAD, 3'b000, 0, 32'h0000_1008, 32'h0,         32'h0000_0103, 32'h80FF_0000, 1, 1, 1, 32'hFFFF_FF80);
    vecs[3]  = mk(1, 0, 5'd3,  1, SEL_LOAD, 3'b100, 0, 32'h0000_100C, 32'h0,         32'h0000_0103, 32'h80FF_0000, 1, 1, 1, 32'h0000_0080);
    vecs[4]  = mk(1, 0, 5'd4,  1, SEL_LOAD, 3'b001, 0, 32'h0000_1010, 32'h0,         32'h0000_0102, 32'h80FF_1234, 1, 1, 1, 32'hFFFF_80FF);
    vecs[5]  = mk(1, 0, 5'd4,  1, SEL_LOAD, 3'b101, 0, 32'h0000_1014, 32'h0,         32'h0000_0101, 32'h1234_8765, 1, 1, 1, 32'h0000_8765);
    vecs[6]  = mk(1, 0, 5'd6,  1, SEL_LOAD, 3'b010, 0, 32'h0000_1018, 32'h0,         32'h0000_0200, 32'hCAFE_F00D, 1, 1, 1, 32'hCAFE_F00D);
    vecs[7]  = mk(1, 0, 5'd6,  1, SEL_LOAD, 3'b011, 0, 32'h0000_101C, 32'h0,         32'h0000_0200, 32'hFFFF_FFFF, 1, 1, 1, 32'h0000_0000);
    vecs[8]  = mk(1, 0, 5'd1,  1, SEL_PC,   3'b000, 0, 32'hFFFF_FFFC, 32'h0,         32'h0,         32'h0,         0, 1, 1, 32'h0000_0000);
    vecs[9]  = mk(1, 0, 5'd1,  1, SEL_PC,   3'b000, 1, 32'h0000_0100, 32'h0,         32'h0,         32'h0,         0, 1, 1, 32'h0000_0102);
    vecs[10] = mk(1, 1, 5'd8,  1, SEL_ALU,  3'b000, 0, 32'h0000_1020, 32'h0000_0055, 32'h0,         32'h0,         0, 0, 0, 32'h0000_0000);
    vecs[11] = mk(1, 0, 5'd0,  1, SEL_ALU,  3'b000, 0, 32'h0000_1024, 32'h0000_0077, 32'h0,         32'h0,         0, 1, 0, 32'h0000_0077);
    vecs[12] = mk(0, 0, 5'd9,  1, SEL_ALU,  3'b000, 0, 32'h0000_1028, 32'h0000_0099, 32'h0,         32'h0,         0, 0, 0, 32'h0000_0000);
    vecs[13] = mk(1, 0, 5'd11, 1, SEL_LOAD, 3'b000, 0, 32'h0000_102C, 32'h0,         32'h0000_0001, 32'h0000_7F00, 1, 1, 1, 32'h0000_007F);

    // reset, then idle: everything reads zero
    rst = 1'b1;
    drive_idle();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_stall", 32'(bus.stallWB), 32'h0);
      check("rst_valid", 32'(bus.validWB), 32'h0);
      check("rst_rd",    32'(bus.rdAddrWB), 32'h0);
      check("rst_we",    32'(bus.rdWriteEnWB), 32'h0);
      check("rst_data",  bus.rdWriteDataWB, 32'h0);
      check("rst_pc",    bus.pcWB, 32'h0);
      check("rst_addr",  bus.dmAddrWB, 32'h0);
      tick();
    end

    // directed single-cycle vectors
    for (int i = 0; i < int'(NV); i++) begin
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d_stall", i), 32'(bus.stallWB), 32'h0);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(bus.validWB), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_we", i),    32'(bus.rdWriteEnWB), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_rd", i),    32'(bus.rdAddrWB), 32'(vecs[i].rd));
      check($sformatf("vec%0d_data", i),  bus.rdWriteDataWB, vecs[i].exp_data);
    end
    drive_idle();
    tick();
    check("idle_we", 32'(bus.rdWriteEnWB), 32'h0);

    // LW with data three cycles late; a held ALU op retires right after
    apply(mk(1, 0, 5'd9, 1, SEL_LOAD, 3'b010, 0, 32'h0000_2000, 32'h0, 32'h0000_0040, 32'h0, 0, 0, 0, 32'h0));
    tick();
    apply(mk(1, 0, 5'd10, 1, SEL_ALU, 3'b000, 0, 32'h0000_2004, 32'h0000_0ABC, 32'h0, 32'h0, 0, 0, 0, 32'h0));
    for (int k = 0; k < 3; k++) begin
      #1;
      check("lw_wait_stall", 32'(bus.stallWB), 32'h1);
      check("lw_wait_we",    32'(bus.rdWriteEnWB), 32'h0);
      tick();
    end
    bus.dmLoadValid = 1'b1;
    bus.dmLoadData  = 32'h1122_3344;
    #1;
    check("lw_arrive_stall", 32'(bus.stallWB), 32'h0);
    check("lw_arrive_we",    32'(bus.rdWriteEnWB), 32'h0);
    tick();
    bus.dmLoadValid = 1'b0;
    #1;
    check("lw_ret_we",   32'(bus.rdWriteEnWB), 32'h1);
    check("lw_ret_rd",   32'(bus.rdAddrWB), 32'd9);
    check("lw_ret_data", bus.rdWriteDataWB, 32'h1122_3344);
    tick();
    drive_idle();
    #1;
    check("held_we",   32'(bus.rdWriteEnWB), 32'h1);
    check("held_rd",   32'(bus.rdAddrWB), 32'd10);
    check("held_data", bus.rdWriteDataWB, 32'h0000_0ABC);
    tick();
    check("held_once_we", 32'(bus.rdWriteEnWB), 32'h0);

    // reset while waiting abandons the load; late data is ignored
    apply(mk(1, 0, 5'd12, 1, SEL_LOAD, 3'b010, 0, 32'h0000_3000, 32'h0, 32'h0000_0080, 32'h0, 0, 0, 0, 32'h0));
    tick();
    drive_idle();
    #1;
    check("rstw_stall_pre", 32'(bus.stallWB), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.dmLoadValid = 1'b1;
    bus.dmLoadData  = 32'hFFFF_FFFF;
    #1;
    check("rstw_stall", 32'(bus.stallWB), 32'h0);
    check("rstw_valid", 32'(bus.validWB), 32'h0);
    tick();
    bus.dmLoadValid = 1'b0;
    #1;
    check("rstw_late_we",   32'(bus.rdWriteEnWB), 32'h0);
    check("rstw_late_data", bus.rdWriteDataWB, 32'h0);

    // flush does not kill an instruction already waiting on its load
    apply(mk(1, 0, 5'd13, 1, SEL_LOAD, 3'b010, 0, 32'h0000_4000, 32'h0, 32'h0000_0044, 32'h0, 0, 0, 0, 32'h0));
    tick();
    bus.flushWB = 1'b1;
    #1;
    check("flw_stall", 32'(bus.stallWB), 32'h1);
    tick();
    bus.flushWB     = 1'b0;
    bus.dmLoadValid = 1'b1;
    bus.dmLoadData  = 32'h0BAD_F00D;
    #1;
    check("flw_arrive_stall", 32'(bus.stallWB), 32'h0);
    tick();
    drive_idle();
    #1;
    check("flw_valid", 32'(bus.validWB), 32'h1);
    check("flw_we",    32'(bus.rdWriteEnWB), 32'h1);
    check("flw_data",  bus.rdWriteDataWB, 32'h0BAD_F00D);
    tick();

    // random traffic against the behavioural model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst                      = (cyc == 0) || ($urandom_range(0, 59) == 0);
      bus.validMEM             = 1'($urandom);
      bus.flushWB              = ($urandom_range(0, 7) == 0);
      bus.rdAddrMEM            = 5'($urandom_range(0, 31));
      bus.rdWriteEnMEM         = ($urandom_range(0, 3) != 0);
      bus.destinationSelectMEM = 2'($urandom);
      bus.loadFunct3MEM        = 3'($urandom);
      bus.isCompressedMEM      = 1'($urandom);
      bus.pcMEM                = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      bus.rdWriteDataMEM       = $urandom;
      bus.dmAddrMEM            = $urandom;
      bus.dmLoadData           = $urandom;
      bus.dmLoadValid          = ($urandom_range(0, 2) == 0);
      #1;
      if (cyc > 0) check_model("rnd");
      model_step();
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
